// File: rtl/nor_flash_pkg.sv
// ============================================================================
// Module      : nor_flash_pkg
// Description : Shared sizing defaults and helpers for the NOR flash model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nor_flash_pkg;

    localparam int unsigned c_addr_w   = 8;
    localparam int unsigned c_data_w   = 8;
    localparam int unsigned c_sector_w = 4;

    localparam logic [c_data_w-1:0] c_erased_word = '1;

    // Sector index of a word address: the bits above the in-sector offset.
    function automatic int unsigned sector_of(input int unsigned addr,
                                              input int unsigned sector_w);
        return addr >> sector_w;
    endfunction

endpackage : nor_flash_pkg

`default_nettype wire

// File: rtl/nor_flash_array.sv
// ============================================================================
// Module      : nor_flash_array
// Description : NOR storage array with AND-only programming and sector erase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nor_flash_array
    import nor_flash_pkg::*;
#(
    parameter int unsigned ADDR_W   = c_addr_w,
    parameter int unsigned DATA_W   = c_data_w,
    parameter int unsigned SECTOR_W = c_sector_w
) (
    input  logic              clk,
    input  logic              i_prog,
    input  logic              i_erase,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int unsigned        c_depth  = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0]  c_erased = {DATA_W{1'b1}};

    // Array powers up erased; there is deliberately no reset path into it.
    logic [DATA_W-1:0] r_mem [c_depth] = '{default: c_erased};

    // Combinational read gives the caller the pre-update word this cycle.
    assign o_rd_data = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_erase) begin
            for (int unsigned i = 0; i < c_depth; i++) begin
                if (sector_of(i, SECTOR_W) == sector_of(32'(i_addr), SECTOR_W)) begin
                    r_mem[ADDR_W'(i)] <= c_erased;
                end
            end
        end else if (i_prog) begin
            r_mem[i_addr] <= r_mem[i_addr] & i_data;
        end
    end

endmodule : nor_flash_array

`default_nettype wire

// File: rtl/nor_flash_memory.sv
// ============================================================================
// Module      : nor_flash_memory
// Description : 256x8 NOR flash model top: arbitration, reset and read register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nor_flash_memory
    import nor_flash_pkg::*;
#(
    parameter int unsigned ADDR_W   = c_addr_w,
    parameter int unsigned DATA_W   = c_data_w,
    parameter int unsigned SECTOR_W = c_sector_w
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic              erase,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic              w_erase;
    logic              w_prog;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] r_data_out;

    // Reset blocks every array update; erase wins over program.
    assign w_erase = erase & ~rst;
    assign w_prog  = we & ~erase & ~rst;

    nor_flash_array #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .SECTOR_W (SECTOR_W)
    ) u_array (
        .clk       (clk),
        .i_prog    (w_prog),
        .i_erase   (w_erase),
        .i_addr    (address),
        .i_data    (data_in),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
        end else if (re) begin
            r_data_out <= w_rd_data;
        end
    end

    assign data_out = r_data_out;

endmodule : nor_flash_memory

`default_nettype wire

// File: tb/tb_nor_flash_memory.sv
// ============================================================================
// Module      : tb_nor_flash_memory
// Description : Self-checking bench for nor_flash_memory against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nor_flash_memory;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic       erase = 1'b0;
    logic [7:0] address = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;

    int tests = 0;
    int fails = 0;

    logic [7:0] model [256];
    logic [7:0] exp_out = 8'h00;
    bit         check_en = 1'b0;

    always #5 clk = ~clk;

    nor_flash_memory dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .re       (re),
        .erase    (erase),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, req, $time);
        end
    endtask

    // Model update uses the flash rules directly: reset first, then read old
    // contents, then erase (whole 16-word sector) or AND-program.
    task automatic op(input logic r, input logic w, input logic rd, input logic e,
                      input logic [7:0] a, input logic [7:0] d);
        int unsigned ai;
        rst = r; we = w; re = rd; erase = e; address = a; data_in = d;
        @(posedge clk);
        ai = int'(a);
        if (r) begin
            exp_out = 8'h00;
        end else begin
            if (rd) exp_out = model[ai];
            if (e) begin
                for (int k = 0; k < 256; k++)
                    if (k / 16 == int'(ai / 16)) model[k] = 8'hFF;
            end else if (w) begin
                model[ai] = model[ai] & d;
            end
        end
        if (r) check_en = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0; we = 1'b0; re = 1'b0; erase = 1'b0;
    endtask

    task automatic prog(input logic [7:0] a, input logic [7:0] d);
        op(1'b0, 1'b1, 1'b0, 1'b0, a, d);
    endtask

    task automatic rd(input logic [7:0] a);
        op(1'b0, 1'b0, 1'b1, 1'b0, a, 8'h00);
    endtask

    // Single compare process: every cycle after the first reset.
    always @(negedge clk) begin
        if (check_en) check("model", data_out, exp_out);
    end

    logic [7:0] pair_addr [7] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    logic [7:0] pair_data [7] = '{8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};

    initial begin
        for (int k = 0; k < 256; k++) model[k] = 8'hFF;
        @(negedge clk);
        #1;

        op(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("reset_out", data_out, 8'h00);
        rd(8'h10);
        check("erased_read", data_out, 8'hFF);

        for (int p = 0; p < 7; p++) begin
            prog(pair_addr[p], pair_data[p]);
            rd(pair_addr[p]);
            check("prog_read", data_out, pair_data[p]);
        end
        op(1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h00);
        check("hold", data_out, 8'h78);

        prog(8'h20, 8'h0F);
        prog(8'h20, 8'hF5);
        rd(8'h20);
        check("and_rule", data_out, 8'h05);
        prog(8'h20, 8'hFF);
        rd(8'h20);
        check("no_set_bits", data_out, 8'h05);

        prog(8'h30, 8'h00);
        prog(8'h3F, 8'h00);
        prog(8'h40, 8'h11);
        op(1'b0, 1'b0, 1'b0, 1'b1, 8'h35, 8'h00);
        rd(8'h30);
        check("erase_lo", data_out, 8'hFF);
        rd(8'h3F);
        check("erase_hi", data_out, 8'hFF);
        rd(8'h40);
        check("erase_other", data_out, 8'h11);

        op(1'b0, 1'b1, 1'b1, 1'b0, 8'h50, 8'h3C);
        check("rbw_old", data_out, 8'hFF);
        rd(8'h50);
        check("rbw_new", data_out, 8'h3C);
        op(1'b0, 1'b1, 1'b0, 1'b1, 8'h60, 8'h00);
        rd(8'h60);
        check("erase_prio", data_out, 8'hFF);

        prog(8'h70, 8'h9A);
        op(1'b1, 1'b0, 1'b1, 1'b0, 8'h70, 8'h00);
        check("rst_read", data_out, 8'h00);
        op(1'b1, 1'b1, 1'b0, 1'b1, 8'h70, 8'h00);
        rd(8'h70);
        check("retained", data_out, 8'h9A);

        rd(8'hFF);
        check("top_addr", data_out, 8'hFF);

        // Random phase over a narrow address window to provoke collisions.
        for (int n = 0; n < 1500; n++) begin
            logic       r_r, r_w, r_rd, r_e;
            logic [7:0] r_a, r_d;
            r_r  = ($urandom_range(0, 63) == 0);
            r_e  = ($urandom_range(0, 19) == 0);
            r_w  = $urandom_range(0, 1) == 1;
            r_rd = $urandom_range(0, 2) != 0;
            r_a  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) r_a = {4'($urandom_range(8, 11)), 4'($urandom_range(0, 15))};
            r_d  = 8'($urandom);
            op(r_r, r_w, r_rd, r_e, r_a, r_d);
        end

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_nor_flash_memory

`default_nettype wire
